tinyalu_responder: RTL and testbench

- DUT-side responder for the TinyALU start/done command protocol; the counterpart of the testbench driver that drives A, B, op and start.
- Accepts one command per handshake, computes the 8-bit x 8-bit operation, and returns a 16-bit result with a single-cycle done pulse.
- Single-cycle ops (add/and/xor) and a multi-cycle multiply share one control FSM.
- Sits directly under the testbench top as the device under test.

---
 rtl/tinyalu_responder.sv | 125 ++++++++++++
 tb/tb_tinyalu_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/tinyalu_responder.sv
// TinyALU responder: accepts one start/done command, computes add/and/xor in one
// cycle or a multiply over MUL_LATENCY edges, and returns a 16-bit result.
module tinyalu_responder #(
    parameter int MUL_LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  logic [2:0]  op,
    input  logic        start,
    output logic        done,
    output logic [15:0] result,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, MUL_WAIT, DONE, WAIT_RELEASE} state_t;

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_RST = 3'b111;

    localparam logic [3:0] CNT_INIT = 4'(MUL_LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] result_q, result_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;

    function automatic logic [15:0] alu_single(input logic [2:0] f, input logic [7:0] x,
                                               input logic [7:0] y);
        logic [15:0] r;
        r = 16'h0000;
        case (f)
            OP_ADD:  r = {7'b0, ({1'b0, x} + {1'b0, y})};
            OP_AND:  r = {8'b0, (x & y)};
            OP_XOR:  r = {8'b0, (x ^ y)};
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        a_d      = a_q;
        b_d      = b_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_ADD, OP_AND, OP_XOR: begin
                            result_d = alu_single(op, A, B);
                            state_d  = DONE;
                        end
                        OP_MUL: begin
                            a_d     = A;
                            b_d     = B;
                            cnt_d   = CNT_INIT;
                            state_d = MUL_WAIT;
                        end
                        OP_RST: begin
                            result_d = 16'h0000;
                            state_d  = WAIT_RELEASE;
                        end
                        default: ;
                    endcase
                end
            end
            MUL_WAIT: begin
                // Product lands on the edge where the counter hits zero; start is ignored here.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d    = 4'd0;
                    result_d = {8'b0, a_q} * {8'b0, b_q};
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = start ? WAIT_RELEASE : IDLE;
            end
            WAIT_RELEASE: begin
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Registered outputs follow the state being entered.
        done_d = (state_d == DONE);
        busy_d = (state_d == MUL_WAIT) || (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            result_q <= 16'h0000;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign done   = done_q;
    assign busy   = busy_q;
    assign result = result_q;

endmodule

// File: tb/tb_tinyalu_responder.sv
// Bench for tinyalu_responder: constant vector table, directed protocol corner
// sequences, and random commands scored against a plain arithmetic model.
module tb_tinyalu_responder;

    localparam int ML = 3;

    localparam logic [2:0] NOP = 3'b000;
    localparam logic [2:0] ADD = 3'b001;
    localparam logic [2:0] ANDO = 3'b010;
    localparam logic [2:0] XORO = 3'b011;
    localparam logic [2:0] MUL = 3'b100;
    localparam logic [2:0] RSTO = 3'b111;

    logic        clk;
    logic        reset_n;
    logic [7:0]  A, B;
    logic [2:0]  op;
    logic        start;
    logic        done;
    logic [15:0] result;
    logic        busy;

    int checks = 0;
    int failures = 0;

    tinyalu_responder #(.MUL_LATENCY(ML)) dut (
        .clk(clk), .reset_n(reset_n), .A(A), .B(B), .op(op), .start(start),
        .done(done), .result(result), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [2:0]  o;
        bit          exp_done;
        logic [15:0] exp_res;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: what a command does to the result register and whether it completes.
    function automatic logic [15:0] model_res(input logic [15:0] prev, input logic [2:0] o,
                                             input logic [7:0] a, input logic [7:0] b);
        int unsigned x, y;
        x = a;
        y = b;
        case (o)
            ADD:     return 16'(x + y);
            ANDO:    return 16'(x & y);
            XORO:    return 16'(x ^ y);
            MUL:     return 16'(x * y);
            RSTO:    return 16'h0000;
            default: return prev;
        endcase
    endfunction

    function automatic bit model_done(input logic [2:0] o);
        return (o == ADD) || (o == ANDO) || (o == XORO) || (o == MUL);
    endfunction

    task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o,
                           input bit exp_done, input logic [15:0] exp_res, input string name);
        int lat, pulses, exp_lat;
        logic [15:0] got;
        exp_lat = (o == MUL) ? ML : 1;
        @(negedge clk);
        A = a; B = b; op = o; start = 1'b1;
        lat = 0; pulses = 0; got = result;
        for (int i = 1; i <= ML + 6; i++) begin
            @(negedge clk);
            if (exp_done && i == 1) begin
                A = 8'($urandom); B = 8'($urandom); op = 3'($urandom);
            end
            if (exp_done && pulses == 0 && i < exp_lat)
                chk({name, "_busy_wait"}, 32'(busy), 32'd1);
            if (done === 1'b1) begin
                pulses++;
                if (pulses == 1) begin
                    lat = i;
                    got = result;
                    chk({name, "_busy_at_done"}, 32'(busy), 32'd1);
                end
                start = 1'b0;
            end else if (pulses > 0 && i == lat + 1) begin
                chk({name, "_busy_after"}, 32'(busy), 32'd0);
            end
        end
        if (exp_done) begin
            chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
            chk({name, "_pulses"}, 32'(pulses), 32'd1);
            chk({name, "_result"}, 32'(got), 32'(exp_res));
        end else begin
            chk({name, "_no_done"}, 32'(pulses), 32'd0);
            chk({name, "_held"}, 32'(result), 32'(exp_res));
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        vec_t vecs[6];
        logic [15:0] ref_res;
        int pulses;
        logic [15:0] got;

        vecs[0] = '{8'hFF, 8'h01, ADD,  1'b1, 16'h0100};
        vecs[1] = '{8'hFF, 8'hFF, MUL,  1'b1, 16'hFE01};
        vecs[2] = '{8'hF0, 8'h3C, ANDO, 1'b1, 16'h0030};
        vecs[3] = '{8'hF0, 8'h3C, XORO, 1'b1, 16'h00CC};
        vecs[4] = '{8'h12, 8'h34, MUL,  1'b1, 16'h03A8};
        vecs[5] = '{8'h55, 8'h66, 3'b110, 1'b0, 16'h03A8};

        reset_n = 1'b0; start = 1'b0; A = 8'h00; B = 8'h00; op = NOP;
        repeat (2) @(negedge clk);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            run_cmd(vecs[i].a, vecs[i].b, vecs[i].o, vecs[i].exp_done, vecs[i].exp_res, "vec");

        // and then xor at minimum spacing
        A = 8'hF0; B = 8'h3C; op = ANDO; start = 1'b1;
        @(negedge clk);
        chk("b2b_and_done", 32'(done), 32'd1);
        chk("b2b_and_res", 32'(result), 32'h0030);
        start = 1'b0;
        @(negedge clk);
        chk("b2b_gap_done", 32'(done), 32'd0);
        op = XORO; start = 1'b1;
        @(negedge clk);
        chk("b2b_xor_done", 32'(done), 32'd1);
        chk("b2b_xor_res", 32'(result), 32'h00CC);
        start = 1'b0;
        @(negedge clk);

        // start held high long after done
        A = 8'h10; B = 8'h20; op = ADD; start = 1'b1;
        pulses = 0; got = 16'h0000;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                pulses++;
                got = result;
            end
        end
        chk("hold_pulses", 32'(pulses), 32'd1);
        chk("hold_result", 32'(got), 32'h0030);
        start = 1'b0;
        @(negedge clk);
        run_cmd(8'h01, 8'h01, ADD, 1'b1, 16'h0002, "after_hold");

        // reset during MUL_WAIT discards the multiply
        A = 8'h12; B = 8'h34; op = MUL; start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_mid_done", 32'(done), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_result", 32'(result), 32'd0);
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        chk("rst_mid_no_done", 32'(pulses), 32'd0);
        chk("rst_mid_result_after", 32'(result), 32'd0);

        // result holding across no_op / illegal, cleared by rst_op
        run_cmd(8'hE9, 8'h14, MUL, 1'b1, 16'h1234, "mul_1234");
        run_cmd(8'hAA, 8'h55, NOP, 1'b0, 16'h1234, "nop_hold");
        run_cmd(8'hAA, 8'h55, 3'b101, 1'b0, 16'h1234, "illegal_hold");
        run_cmd(8'hAA, 8'h55, RSTO, 1'b0, 16'h0000, "rst_op");

        ref_res = 16'h0000;
        for (int n = 0; n < 40; n++) begin
            logic [7:0] ra, rb;
            logic [2:0] ro;
            ra = 8'($urandom);
            rb = 8'($urandom);
            ro = 3'($urandom_range(0, 7));
            ref_res = model_res(ref_res, ro, ra, rb);
            run_cmd(ra, rb, ro, model_done(ro), ref_res, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
